uart_rx_frame_ctrl: RTL

Frame controller for the UART receiver. It detects the start bit, runs the per-bit edge counter and enables the three-sample majority-vote sampler. It consumes the sampler's `sampled_bit` once per bit period, deserializes the data LSB-first, checks optional parity and the stop bit, and presents the received byte with a one-cycle valid strobe. It sits between the raw `RX_IN` line and the receiver's parallel output, wrapped around the sampler.

---
 rtl/uart_rx_pkg.sv | 41 ++++
 rtl/uart_rx_frame_ctrl_edge_bit_counter.sv | 71 +++++++
 rtl/uart_rx_frame_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared definitions for the UART receiver frame controller.
//                Holds the frame state encoding, the legal oversampling
//                ratios, the parity-type codes and a helper that maps a
//                Prescale code to its last edge index within a bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Frame state encoding (explicit 3-bit width)
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Legal oversampling ratios as seen on the 5-bit Prescale port.
    // 32 does not fit in five bits, so it arrives as its low five bits (0).
    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;
    localparam logic [4:0] PRESCALE_32 = 5'd0;

    // Parity type codes for PAR_TYP
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Last edge index (P-1) for a Prescale code; anything illegal runs as P=8.
    function automatic logic [4:0] prescale_last_edge(input logic [4:0] prescale);
        logic [4:0] last_edge;
        case (prescale)
            PRESCALE_16: last_edge = 5'd15;
            PRESCALE_32: last_edge = 5'd31;
            default:     last_edge = 5'd7;
        endcase
        return last_edge;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl_edge_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_bit_counter
//  Description : Per-bit edge counter and data-bit counter for the UART
//                receiver frame controller.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_start         - start detected in IDLE (edge 0 seen)
//                i_enable        - frame in progress (not IDLE)
//                i_bit_en        - DATA state: count data bits
//                i_last_edge     - latched P-1
//                o_edge_cnt      - edge index within current bit
//                o_bit_cnt       - data bit index
//                o_end_of_bit    - current cycle is edge P-1
//                o_last_bit      - bit index is DATA_WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_bit_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_enable,
    input  logic                 i_bit_en,
    input  logic [4:0]           i_last_edge,
    output logic [4:0]           o_edge_cnt,
    output logic [BIT_CNT_W-1:0] o_bit_cnt,
    output logic                 o_end_of_bit,
    output logic                 o_last_bit
);

    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic [4:0]           r_edge_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 w_end_of_bit;

    assign w_end_of_bit = i_enable && (r_edge_cnt == i_last_edge);

    // The start-detect cycle is edge 0, so the counter resumes at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= 5'd0;
        end else if (i_start) begin
            r_edge_cnt <= 5'd1;
        end else if (!i_enable || w_end_of_bit) begin
            r_edge_cnt <= 5'd0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
        end
    end

    // Bit index only lives in DATA; it is held at 0 everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (!i_bit_en) begin
            r_bit_cnt <= '0;
        end else if (w_end_of_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign o_edge_cnt   = r_edge_cnt;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_end_of_bit = w_end_of_bit;
    assign o_last_bit   = (r_bit_cnt == c_LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_ctrl
//  Description : UART receiver frame controller. Detects the start bit,
//                runs the edge/bit counters, enables the majority sampler,
//                deserializes LSB-first, checks parity and stop bit and
//                reports the frame result with one-cycle strobes.
//  Ports       : uart_rx_frame_ctrl_clk/_rst - clock, sync active-high reset
//                RX_IN       - serial line (idle high)
//                PAR_EN      - parity bit present
//                PAR_TYP     - 0 even / 1 odd parity
//                Prescale    - oversampling ratio code (8, 16, 32)
//                sampled_bit - majority-voted bit from the sampler
//                edge_cnt    - edge index within the current bit
//                dat_samp_en - sampler enable
//                P_DATA      - last good received word
//                data_valid  - P_DATA updated strobe
//                par_err     - parity mismatch strobe
//                stp_err     - stop bit read as 0 strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  uart_rx_frame_ctrl_clk,
    input  logic                  uart_rx_frame_ctrl_rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            Prescale,
    input  logic                  sampled_bit,
    output logic [4:0]            edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int c_BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [4:0]             r_last_edge;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_par_pend;
    logic [DATA_WIDTH-1:0]  r_p_data;
    logic                   r_data_valid;
    logic                   r_par_err;
    logic                   r_stp_err;

    logic                   w_start;
    logic                   w_busy;
    logic                   w_bit_en;
    logic                   w_eob;
    logic                   w_last_bit;
    logic [c_BIT_CNT_W-1:0] w_bit_cnt;
    logic [4:0]             w_edge_cnt;

    edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIT_CNT_W  (c_BIT_CNT_W)
    ) u_edge_bit_counter (
        .clk          (uart_rx_frame_ctrl_clk),
        .rst          (uart_rx_frame_ctrl_rst),
        .i_start      (w_start),
        .i_enable     (w_busy),
        .i_bit_en     (w_bit_en),
        .i_last_edge  (r_last_edge),
        .o_edge_cnt   (w_edge_cnt),
        .o_bit_cnt    (w_bit_cnt),
        .o_end_of_bit (w_eob),
        .o_last_bit   (w_last_bit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge uart_rx_frame_ctrl_clk) begin
        if (uart_rx_frame_ctrl_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!RX_IN) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                // A start bit that reads back high mid-bit was a glitch.
                if (w_eob) begin
                    w_next_state = sampled_bit ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_eob && w_last_bit) begin
                    w_next_state = PAR_EN ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: begin
                if (w_eob) begin
                    w_next_state = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_eob) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        w_busy      = (r_state != c_ST_IDLE);
        w_start     = (r_state == c_ST_IDLE) && !RX_IN;
        w_bit_en    = (r_state == c_ST_DATA);
        dat_samp_en = w_busy;
    end

    // ------------------------------------------------------------------
    // Datapath: prescale latch, shift register, checks, result strobes
    // ------------------------------------------------------------------
    always_ff @(posedge uart_rx_frame_ctrl_clk) begin
        if (uart_rx_frame_ctrl_rst) begin
            r_last_edge  <= 5'd7;
            r_shift      <= '0;
            r_par_pend   <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            // Prescale is frozen for the whole frame at start detection.
            if (w_start) begin
                r_last_edge <= prescale_last_edge(Prescale);
                r_par_pend  <= 1'b0;
            end

            if ((r_state == c_ST_DATA) && w_eob) begin
                r_shift[w_bit_cnt] <= sampled_bit;
            end

            if ((r_state == c_ST_PARITY) && w_eob) begin
                r_par_pend <= (sampled_bit != ((^r_shift) ^ PAR_TYP));
            end

            // Frame verdict is registered so all strobes align one cycle later.
            if ((r_state == c_ST_STOP) && w_eob) begin
                r_stp_err <= !sampled_bit;
                r_par_err <= r_par_pend;
                if (sampled_bit && !r_par_pend) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end
            end
        end
    end

    assign edge_cnt   = w_edge_cnt;
    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire
